allpass_coef_bank: RTL and testbench

Double-buffered coefficient register bank that feeds the packed coefficient bus `c` of the allpass filter stage. A host or control block streams one complete coefficient set, one word per handshake, into a shadow bank. The set is copied atomically into the active bank on a sample-aligned swap strobe, so the filter never sees a partially updated set. Malformed frames are discarded and flagged.

---
 rtl/allpass_coef_bank_if.sv | 24 ++
 rtl/allpass_coef_bank.sv | 171 +++++++++++++++++
 tb/tb_allpass_coef_bank.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/allpass_coef_bank_if.sv
// Coefficient write channel into allpass_coef_bank: one signed word per
// valid/ready handshake, with wr_last marking the final word of a set.
interface allpass_coef_bank_if #(
  parameter int WIDTH = 16
);
  logic             wr_valid;
  logic             wr_ready;
  logic [WIDTH-1:0] wr_data;
  logic             wr_last;

  modport master (
    output wr_valid,
    output wr_data,
    output wr_last,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_data,
    input  wr_last,
    output wr_ready
  );
endinterface

// File: rtl/allpass_coef_bank.sv
// Double-buffered coefficient bank for the allpass stage: a shadow set is filled word by word
// and copied atomically into the active bus c on a swap strobe. ALLPASS_COEF_CLAMP_EN enables saturation.
module allpass_coef_bank #(
  parameter int WIDTH      = 16,
  parameter int FIXEDPOINT = 14,
  parameter int N          = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  allpass_coef_bank_if.slave       wr,
  input  logic                     swap_en,
  output logic [WIDTH*(N-1)-1:0]   c,
  output logic                     pending,
  output logic                     swapped,
  output logic                     err,
  output logic                     clamped
);

  localparam int NW    = N - 1;
  localparam int IDX_W = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 2);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_FILL    = 2'd1;
  localparam logic [1:0] ST_PENDING = 2'd2;

  if (N < 3 || FIXEDPOINT < 2 || FIXEDPOINT > WIDTH) begin : g_param_range_bad
    $error("allpass_coef_bank: N must be >= 3 and 2 <= FIXEDPOINT <= WIDTH");
  end

  logic [1:0]              state_r;
  logic [IDX_W-1:0]        idx_r;
  logic                    ready_r;
  logic                    pending_r;
  logic                    swapped_r;
  logic                    err_r;
  logic                    clamped_r;
  logic [WIDTH*NW-1:0]     c_r;
  logic [WIDTH-1:0]        shadow_r [NW];

  logic                    xfer_s;
  logic                    at_last_s;
  logic                    frame_err_s;
  logic                    store_s;
  logic                    final_s;
  logic                    swap_s;
  logic signed [WIDTH-1:0] word_s;
  logic                    clip_s;

`ifdef ALLPASS_COEF_CLAMP_EN
  localparam logic signed [WIDTH-1:0] COEF_MAX = WIDTH'((2 ** (FIXEDPOINT - 1)) - 1);
  localparam logic signed [WIDTH-1:0] COEF_MIN = -COEF_MAX;

  function automatic logic signed [WIDTH-1:0] sat_word(input logic signed [WIDTH-1:0] w);
    logic signed [WIDTH-1:0] r;
    if (w > COEF_MAX) begin
      r = COEF_MAX;
    end else if (w < COEF_MIN) begin
      r = COEF_MIN;
    end else begin
      r = w;
    end
    return r;
  endfunction

  // Saturate incoming word to strictly below unity magnitude.
  always_comb begin
    word_s = sat_word(wr.wr_data);
    clip_s = (word_s != wr.wr_data);
  end
`else
  assign word_s = wr.wr_data;
  assign clip_s = 1'b0;
`endif

  // Handshake and framing decode; ready is low in PENDING, so transfers only occur while filling.
  always_comb begin
    xfer_s      = wr.wr_valid & ready_r;
    at_last_s   = (idx_r == LAST_IDX);
    frame_err_s = xfer_s & (wr.wr_last != at_last_s);
    store_s     = xfer_s & ~frame_err_s;
    final_s     = store_s & wr.wr_last;
    swap_s      = (state_r == ST_PENDING) & swap_en;
  end

  // Frame control state machine and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      idx_r     <= '0;
      ready_r   <= 1'b1;
      pending_r <= 1'b0;
      swapped_r <= 1'b0;
      err_r     <= 1'b0;
      clamped_r <= 1'b0;
    end else begin
      swapped_r <= 1'b0;
      err_r     <= frame_err_s;
      clamped_r <= store_s & clip_s;
      case (state_r)
        ST_IDLE, ST_FILL: begin
          if (frame_err_s) begin
            state_r <= ST_IDLE;
            idx_r   <= '0;
          end else if (final_s) begin
            state_r   <= ST_PENDING;
            idx_r     <= '0;
            ready_r   <= 1'b0;
            pending_r <= 1'b1;
          end else if (store_s) begin
            state_r <= ST_FILL;
            idx_r   <= idx_r + IDX_W'(1);
          end else begin
            state_r <= state_r;
            idx_r   <= idx_r;
          end
        end
        ST_PENDING: begin
          if (swap_s) begin
            state_r   <= ST_IDLE;
            ready_r   <= 1'b1;
            pending_r <= 1'b0;
            swapped_r <= 1'b1;
          end else begin
            state_r <= ST_PENDING;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          idx_r     <= '0;
          ready_r   <= 1'b1;
          pending_r <= 1'b0;
        end
      endcase
    end
  end

  // Shadow bank: one slot written per accepted word; dropped words never land here.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NW; k++) begin
        shadow_r[k] <= '0;
      end
    end else if (store_s) begin
      shadow_r[idx_r] <= word_s;
    end else begin
      shadow_r <= shadow_r;
    end
  end

  // Active bank: every word replaced on the same swap edge so the filter never sees a mixed set.
  always_ff @(posedge clk) begin
    if (rst) begin
      c_r <= '0;
    end else if (swap_s) begin
      for (int k = 0; k < NW; k++) begin
        c_r[k*WIDTH +: WIDTH] <= shadow_r[k];
      end
    end else begin
      c_r <= c_r;
    end
  end

  assign wr.wr_ready = ready_r;
  assign c           = c_r;
  assign pending     = pending_r;
  assign swapped     = swapped_r;
  assign err         = err_r;
  assign clamped     = clamped_r;

endmodule

// File: tb/tb_allpass_coef_bank.sv
// Directed bench for allpass_coef_bank: a queue-based set model checked every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_allpass_coef_bank;
  localparam int W  = 16;
  localparam int FP = 14;
  localparam int N  = 7;
  localparam int NW = N - 1;
  localparam int CW = W * NW;

`ifdef ALLPASS_COEF_CLAMP_EN
  localparam bit CLAMP_ON = 1'b1;
`else
  localparam bit CLAMP_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          swap_en;
  logic [CW-1:0] c;
  logic          pending, swapped, err, clamped;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  allpass_coef_bank_if #(.WIDTH(W)) wr ();

  allpass_coef_bank #(.WIDTH(W), .FIXEDPOINT(FP), .N(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .wr      (wr),
    .swap_en (swap_en),
    .c       (c),
    .pending (pending),
    .swapped (swapped),
    .err     (err),
    .clamped (clamped)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [W-1:0] m_q [$];
  logic [W-1:0] m_c [NW];
  bit m_pending, m_swapped, m_err, m_clamped, m_hit;

  function automatic logic [W-1:0] model_sat(input logic [W-1:0] w, output bit hit);
    int v;
    int lim;
    v   = int'($signed(w));
    lim = (1 << (FP - 1)) - 1;
    hit = 1'b0;
    if (CLAMP_ON && v > lim) begin
      v = lim; hit = 1'b1;
    end else if (CLAMP_ON && v < -lim) begin
      v = -lim; hit = 1'b1;
    end
    return W'(v);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      for (int k = 0; k < NW; k++) m_c[k] = '0;
      m_pending = 0; m_swapped = 0; m_err = 0; m_clamped = 0;
    end else begin
      m_swapped = 0; m_err = 0; m_clamped = 0;
      if (m_pending) begin
        if (swap_en) begin
          for (int k = 0; k < NW; k++) m_c[k] = m_q[k];
          m_q.delete();
          m_pending = 0;
          m_swapped = 1;
        end
      end else if (wr.wr_valid) begin
        if (wr.wr_last != (m_q.size() == NW - 1)) begin
          m_err = 1;
          m_q.delete();
        end else begin
          m_q.push_back(model_sat(wr.wr_data, m_hit));
          m_clamped = m_hit;
          if (wr.wr_last) m_pending = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [CW-1:0] exp_c;
      for (int k = 0; k < NW; k++) exp_c[k*W +: W] = m_c[k];
      check("model_c", c, exp_c);
      check("model_ready", CW'(wr.wr_ready), CW'(!m_pending));
      check("model_pending", CW'(pending), CW'(m_pending));
      check("model_swapped", CW'(swapped), CW'(m_swapped));
      check("model_err", CW'(err), CW'(m_err));
      check("model_clamped", CW'(clamped), CW'(m_clamped));
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [W-1:0] d, input logic last);
    wr.wr_valid = 1'b1;
    wr.wr_data  = d;
    wr.wr_last  = last;
    @(negedge clk);
    wr.wr_valid = 1'b0;
    wr.wr_last  = 1'b0;
  endtask

  localparam logic [CW-1:0] SET1 = 96'h0006_0005_0004_0003_0002_0001;
  localparam logic [CW-1:0] SET2 = 96'h000F_000E_000D_000C_000B_000A;
  localparam logic [CW-1:0] SET3 = 96'h0024_0023_0022_0021_0020_001F;
  localparam logic [CW-1:0] SETC_CLAMP = 96'h0004_0003_0002_0001_E001_1FFF;
  localparam logic [CW-1:0] SETC_RAW   = 96'h0004_0003_0002_0001_8000_7FFF;

  initial begin
    rst = 1'b1; swap_en = 1'b0;
    wr.wr_valid = 1'b0; wr.wr_data = '0; wr.wr_last = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_c", c, '0);
    check("reset_ready", CW'(wr.wr_ready), CW'(1));
    check("reset_pending", CW'(pending), '0);
    rst = 1'b0;

    // basic set with swap_en tied high: swap exactly one edge after the final word
    swap_en = 1'b1;
    for (int i = 1; i <= 6; i++) send(W'(i), i == 6);
    check("final_pending", CW'(pending), CW'(1));
    check("final_c_old", c, '0);
    @(negedge clk);
    check("set1_c", c, SET1);
    check("set1_swapped", CW'(swapped), CW'(1));
    check("set1_ready", CW'(wr.wr_ready), CW'(1));

    // hold in PENDING with swap_en low while wr_valid is driven
    swap_en = 1'b0;
    for (int i = 0; i < 6; i++) send(W'(10 + i), i == 5);
    wr.wr_valid = 1'b1; wr.wr_data = 16'd99;
    repeat (20) @(negedge clk);
    check("hold_ready", CW'(wr.wr_ready), '0);
    check("hold_pending", CW'(pending), CW'(1));
    check("hold_c", c, SET1);
    wr.wr_valid = 1'b0;
    swap_en = 1'b1;
    @(negedge clk);
    swap_en = 1'b0;
    check("set2_swapped", CW'(swapped), CW'(1));
    check("set2_c", c, SET2);
    @(negedge clk);
    check("set2_swapped_clear", CW'(swapped), '0);

    // early wr_last on the 3rd word
    swap_en = 1'b1;
    send(16'd21, 1'b0);
    send(16'd22, 1'b0);
    send(16'd23, 1'b1);
    check("early_last_err", CW'(err), CW'(1));
    check("early_last_c", c, SET2);
    for (int i = 0; i < 6; i++) send(W'(31 + i), i == 5);
    @(negedge clk);
    check("set3_c", c, SET3);

    // missing wr_last on the 6th word
    for (int i = 0; i < 6; i++) send(W'(40 + i), 1'b0);
    check("late_last_err", CW'(err), CW'(1));
    check("late_last_pending", CW'(pending), '0);
    @(negedge clk);
    check("late_last_c", c, SET3);
    check("late_last_noswap", CW'(swapped), '0);

    // reset while a set is pending
    swap_en = 1'b0;
    for (int i = 0; i < 6; i++) send(W'(50 + i), i == 5);
    check("prerst_pending", CW'(pending), CW'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_c", c, '0);
    check("rst_pending", CW'(pending), '0);
    check("rst_ready", CW'(wr.wr_ready), CW'(1));

    // out-of-range words
    swap_en = 1'b1;
    send(16'h7FFF, 1'b0);
    check("clamp_pos", CW'(clamped), CW'(CLAMP_ON));
    send(16'h8000, 1'b0);
    check("clamp_neg", CW'(clamped), CW'(CLAMP_ON));
    for (int i = 1; i <= 4; i++) send(W'(i), i == 4);
    check("clamp_small", CW'(clamped), '0);
    @(negedge clk);
    check("clamp_c", c, CLAMP_ON ? SETC_CLAMP : SETC_RAW);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
